// File: rtl/circuito_memoria_param.sv
// Memory-sequence game: the player must reproduce a one-hot ROM sequence on the switches.
// One jogada per rising edge of "any switch on"; optional per-jogada timeout.
module circuito_memoria_param #(
    parameter int unsigned W       = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 0,
    localparam int unsigned AW     = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic [W-1:0]  chaves,
    output logic          pronto,
    output logic          acertou,
    output logic          errou,
    output logic          timeout,
    output logic          db_igual,
    output logic [AW-1:0] db_contagem,
    output logic [W-1:0]  db_memoria,
    output logic [W-1:0]  db_jogada,
    output logic [3:0]    db_estado
);

    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        StInicial    = 4'h0,
        StPrepara    = 4'h1,
        StEspera     = 4'h2,
        StRegistra   = 4'h3,
        StCompara    = 4'h4,
        StProximo    = 4'h5,
        StFimAcertou = 4'hA,
        StFimErrou   = 4'hE,
        StFimTimeout = 4'hD
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [W-1:0]    jogada_q;
    logic [W-1:0]    chaves_prev_q;
    logic [TW-1:0]   tmo_q;
    logic [W-1:0]    rom [DEPTH];
    logic            jogada_ev;
    logic            tmo_hit;
    logic            last_addr;

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
        assign rom[i] = W'(1) << (i % int'(W));
    end

    assign db_memoria = rom[addr_q];
    assign db_igual   = (jogada_q == db_memoria);
    assign jogada_ev  = (|chaves) && !(|chaves_prev_q);
    assign tmo_hit    = (TIMEOUT > 0) && (tmo_q == TW'(TLAST));
    assign last_addr  = (addr_q == AW'(DEPTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StInicial;
            addr_q        <= '0;
            jogada_q      <= '0;
            chaves_prev_q <= '0;
            tmo_q         <= '0;
        end else begin
            chaves_prev_q <= chaves;
            case (state_q)
                StInicial: if (iniciar) state_q <= StPrepara;
                StPrepara: begin
                    addr_q   <= '0;
                    jogada_q <= '0;
                    tmo_q    <= '0;
                    state_q  <= StEspera;
                end
                StEspera: begin
                    // A jogada arriving on the expiry clock takes priority over the timeout.
                    if (jogada_ev) begin
                        state_q <= StRegistra;
                    end else if (tmo_hit) begin
                        state_q <= StFimTimeout;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                StRegistra: begin
                    jogada_q <= chaves;
                    state_q  <= StCompara;
                end
                StCompara: begin
                    if (!db_igual)     state_q <= StFimErrou;
                    else if (last_addr) state_q <= StFimAcertou;
                    else               state_q <= StProximo;
                end
                StProximo: begin
                    addr_q  <= addr_q + AW'(1);
                    tmo_q   <= '0;
                    state_q <= StEspera;
                end
                StFimAcertou, StFimErrou, StFimTimeout: begin
                    if (iniciar) state_q <= StPrepara;
                end
                default: state_q <= StInicial;
            endcase
        end
    end

    assign pronto      = (state_q == StFimAcertou) || (state_q == StFimErrou) ||
                         (state_q == StFimTimeout);
    assign acertou     = (state_q == StFimAcertou);
    assign errou       = (state_q == StFimErrou);
    assign timeout     = (state_q == StFimTimeout);
    assign db_contagem = addr_q;
    assign db_jogada   = jogada_q;
    assign db_estado   = state_q;

endmodule

// File: tb/tb_circuito_memoria_param.sv
// Directed bench for circuito_memoria_param with W=4, DEPTH=4, TIMEOUT=20 (ROM = 1,2,4,8).
module tb_circuito_memoria_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = '0;
    logic       pronto, acertou, errou, timeout, db_igual;
    logic [1:0] db_contagem;
    logic [3:0] db_memoria, db_jogada, db_estado;

    int n_checks = 0;
    int n_errs   = 0;

    circuito_memoria_param #(
        .W       (4),
        .DEPTH   (4),
        .TIMEOUT (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .pronto      (pronto),
        .acertou     (acertou),
        .errou       (errou),
        .timeout     (timeout),
        .db_igual    (db_igual),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_jogada   (db_jogada),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Switch pattern held 3 clocks (reaches PROXIMO/final), then released for 2.
    task automatic press(input logic [3:0] val);
        chaves = val;
        step(3);
        chaves = '0;
        step(2);
    endtask

    task automatic start();
        iniciar = 1'b1;
        step(1);
        check("prepara", db_estado, 4'h1);
        iniciar = 1'b0;
        step(1);
        check("espera_after_start", db_estado, 4'h2);
        check("addr_after_start", db_contagem, 2'd0);
    endtask

    initial begin
        step(2);
        check("rst_estado", db_estado, 4'h0);
        check("rst_pronto", pronto, 1'b0);
        check("rst_flags", {acertou, errou, timeout}, 3'b000);
        check("rst_contagem", db_contagem, 2'd0);
        check("rst_jogada", db_jogada, 4'h0);
        reset = 1'b0;
        step(2);
        check("idle_stays", db_estado, 4'h0);

        // Full correct sequence with latency checks on the first jogada
        start();
        check("mem0", db_memoria, 4'h1);
        chaves = 4'h1;
        step(1);
        check("lat_registra", db_estado, 4'h3);
        step(1);
        check("lat_compara", db_estado, 4'h4);
        check("jogada_1", db_jogada, 4'h1);
        check("igual_1", db_igual, 1'b1);
        step(1);
        check("lat_proximo", db_estado, 4'h5);
        step(1);
        check("back_espera", db_estado, 4'h2);
        check("addr_1", db_contagem, 2'd1);
        chaves = '0;
        step(1);
        press(4'h2);
        press(4'h4);
        check("addr_3", db_contagem, 2'd3);
        press(4'h8);
        check("acertou", acertou, 1'b1);
        check("acertou_pronto", pronto, 1'b1);
        check("acertou_estado", db_estado, 4'hA);
        check("acertou_addr", db_contagem, 2'd3);
        check("acertou_errou", errou, 1'b0);

        // Restart from final, wrong second jogada
        start();
        check("restart_jogada", db_jogada, 4'h0);
        press(4'h1);
        press(4'h4);
        check("errou", errou, 1'b1);
        check("errou_addr", db_contagem, 2'd1);
        check("errou_jogada", db_jogada, 4'h4);
        check("errou_estado", db_estado, 4'hE);
        check("errou_acertou", acertou, 1'b0);

        // Timeout after exactly 20 clocks in ESPERA
        start();
        step(19);
        check("tmo_not_yet", db_estado, 4'h2);
        step(1);
        check("tmo_estado", db_estado, 4'hD);
        check("tmo_flag", timeout, 1'b1);
        check("tmo_pronto", pronto, 1'b1);

        // Jogada on the 20th clock wins over the timeout
        start();
        step(19);
        chaves = 4'h1;
        step(1);
        check("tmo_jogada_wins", db_estado, 4'h3);
        step(3);
        check("held_espera", db_estado, 4'h2);
        step(5);
        check("held_no_second", db_estado, 4'h2);
        check("held_addr", db_contagem, 2'd1);
        iniciar = 1'b1;
        step(1);
        check("iniciar_ignored", db_estado, 4'h2);
        iniciar = 1'b0;
        chaves = '0;
        step(1);
        press(4'h2);
        check("addr_2", db_contagem, 2'd2);

        // Mid-sequence reset discards progress
        reset = 1'b1;
        step(1);
        check("midreset_estado", db_estado, 4'h0);
        check("midreset_addr", db_contagem, 2'd0);
        reset = 1'b0;
        start();

        // Multi-bit switches never match a one-hot word
        press(4'h3);
        check("multibit_errou", db_estado, 4'hE);
        check("multibit_jogada", db_jogada, 4'h3);

        // Reset beats iniciar
        reset = 1'b1;
        iniciar = 1'b1;
        step(1);
        check("reset_priority", db_estado, 4'h0);
        reset = 1'b0;
        iniciar = 1'b0;
        step(1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
